rca: RTL and testbench

The `rca` block is a parameterised ripple-carry adder that adds two unsigned operands and a carry-in. The sum and carry-out are registered on the rising clock edge. It is a basic arithmetic leaf cell for datapaths that need a simple, area-minimal adder with a one-cycle registered result. The carry chain is built from WIDTH explicit full-adder stages, with bit 0 at the LSB.

---
 rtl/rca.sv | 54 +++++
 tb/tb_rca.sv | 135 +++++++++++++
 2 files changed

// File: rtl/rca.sv
// Parameterised ripple-carry adder with a registered sum, carry-out and
// two's-complement overflow flag. One result is captured every clock.
module rca #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    logic [WIDTH:0]   c;
    logic [WIDTH-1:0] s;

    logic [WIDTH-1:0] sum_d, sum_q;
    logic             cout_d, cout_q;
    logic             ovf_d, ovf_q;

    assign c[0] = cin;

    // One explicit full-adder cell per bit; each carry feeds the next stage.
    for (genvar i = 0; i < WIDTH; i++) begin : g_stage
        assign s[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    always_comb begin
        sum_d  = s;
        cout_d = c[WIDTH];
        // With WIDTH = 1, c[WIDTH-1] is cin, so one expression covers all widths.
        ovf_d  = c[WIDTH-1] ^ c[WIDTH];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q  <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            sum_q  <= sum_d;
            cout_q <= cout_d;
            ovf_q  <= ovf_d;
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_rca.sv
// Directed bench for rca: reset behaviour, corner additions, a counting
// sweep and a mid-stream asynchronous reset, checked against a queue.
module tb_rca;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] a   = '0;
    logic [W-1:0] b   = '0;
    logic         cin = 1'b0;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    int checks = 0;
    int errors = 0;

    // Entries are {ovf, cout, sum}.
    logic [W+1:0] exp_q[$];
    logic [W+1:0] last_exp;

    rca #(.WIDTH(W)) dut (
        .clk  (clk),
        .rst  (rst),
        .a    (a),
        .b    (b),
        .cin  (cin),
        .sum  (sum),
        .cout (cout),
        .ovf  (ovf)
    );

    always #5 clk = ~clk;

    // Reference: wide unsigned add, and signed overflow from operand/result signs.
    function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic ci);
        logic [W:0] t;
        logic       o;
        t = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
        o = (x[W-1] == y[W-1]) && (t[W-1] != x[W-1]);
        return {o, t};
    endfunction

    task automatic check(input string tag, input logic [W+1:0] obs, input logic [W+1:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed ovf/cout/sum=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic apply(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci);
        a   = x;
        b   = y;
        cin = ci;
        exp_q.push_back(model(x, y, ci));
    endtask

    task automatic drive(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci);
        @(negedge clk);
        apply(x, y, ci);
    endtask

    task automatic collect(input string tag);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s: observed no pending result expected=one queued", tag);
        end else begin
            last_exp = exp_q.pop_front();
            check(tag, {ovf, cout, sum}, last_exp);
        end
    endtask

    task automatic step(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic ci);
        drive(x, y, ci);
        collect(tag);
    endtask

    initial begin
        // Reset held with busy inputs: outputs stay zero across edges.
        a   = 8'hAA;
        b   = 8'h55;
        cin = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_hold", {ovf, cout, sum}, '0);

        @(negedge clk);
        rst = 1'b0;
        apply(8'hAA, 8'h55, 1'b1);
        collect("reset_release");

        step("zero",       8'h00, 8'h00, 1'b0);
        step("zero_cin",   8'h00, 8'h00, 1'b1);
        step("ripple_ff1", 8'hFF, 8'h01, 1'b0);
        step("ripple_all", 8'hFF, 8'hFF, 1'b1);
        step("ovf_pos",    8'h7F, 8'h01, 1'b0);
        step("ovf_neg",    8'h80, 8'h80, 1'b0);

        // Input changes between edges must not reach the outputs.
        a = 8'h12;
        b = 8'h34;
        #3;
        check("hold_between_edges", {ovf, cout, sum}, last_exp);

        for (int i = 0; i < 48; i++) begin
            step("sweep", W'(i), W'(i / 2), 1'((i / 4) % 2));
        end

        // Asynchronous reset raised between edges while sum is nonzero.
        step("pre_async", 8'h30, 8'h05, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst", {ovf, cout, sum}, '0);
        @(posedge clk);
        #1;
        check("async_rst_edge", {ovf, cout, sum}, '0);
        @(negedge clk);
        rst = 1'b0;
        apply(8'hC0, 8'hC0, 1'b1);
        collect("after_release");
        step("after_release2", 8'h01, 8'h02, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
